// File: rtl/bist_ctrl_param.sv
// rtl/bist_ctrl_param.sv - parametrised LFSR/MISR BIST controller (optional BIST_SIG_OUT_EN adds sig_out/sig_valid)
module bist_ctrl_param #(
    parameter int              IN_W       = 8,
    parameter int              OUT_W      = 8,
    parameter int              N_PATTERNS = 200,
    parameter int              CUT_LAT    = 0,
    parameter logic [IN_W-1:0]  LFSR_POLY  = 8'hB8,
    parameter logic [IN_W-1:0]  LFSR_SEED  = 8'h01,
    parameter logic [OUT_W-1:0] MISR_POLY  = 8'hB8,
    parameter logic [OUT_W-1:0] MISR_SEED  = 8'h00,
    parameter logic [OUT_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic [IN_W-1:0]  func_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic [IN_W-1:0]  cut_in,
    output logic             bist_mode,
    output logic             pass_fail,
`ifdef BIST_SIG_OUT_EN
    output logic [OUT_W-1:0] sig_out,
    output logic             sig_valid,
`endif
    output logic             bist_end
);

    // Total RUN length: the patterns plus the cycles needed to flush the CUT pipeline.
    localparam int TOTAL = N_PATTERNS + CUT_LAT;
    localparam int CNT_W = (TOTAL + 1 > 2) ? $clog2(TOTAL + 1) : 1;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

    // Reject out-of-range configurations at elaboration time.
    if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
        $error("bist_ctrl_param: IN_W out of range");
    end
    if (OUT_W < 2 || OUT_W > 32) begin : g_bad_out_w
        $error("bist_ctrl_param: OUT_W out of range");
    end
    if (N_PATTERNS < 1 || N_PATTERNS > 65535) begin : g_bad_n
        $error("bist_ctrl_param: N_PATTERNS out of range");
    end
    if (CUT_LAT < 0 || CUT_LAT > 7) begin : g_bad_lat
        $error("bist_ctrl_param: CUT_LAT out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  lfsr;
    logic [OUT_W-1:0] misr;
    logic [CNT_W-1:0] counter;
    logic             start_q;

    logic             start_pulse;
    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;
    logic             capture;
    logic             last_cycle;

    // Edge detect so a held bist_start launches only one run.
    assign start_pulse = bist_start & ~start_q;

    // Fibonacci-style shift with parity of the tapped bits fed into bit 0.
    assign lfsr_next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_POLY)};
    assign misr_next = {misr[OUT_W-2:0], ^(misr & MISR_POLY)} ^ cut_out;

    // Responses are only meaningful once the first pattern has crossed the CUT pipeline.
    assign capture    = (int'(counter) >= CUT_LAT) && (int'(counter) < TOTAL);
    assign last_cycle = (int'(counter) == TOTAL - 1);

    // CUT input mux: LFSR patterns while testing, functional inputs otherwise.
    assign cut_in = bist_mode ? lfsr : func_in;

`ifdef BIST_SIG_OUT_EN
    // Expose the live signature for golden-value extraction; valid once the run is done.
    assign sig_out   = misr;
    assign sig_valid = bist_end;
`endif

    // Controller FSM with registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            lfsr      <= SEED_EFF;
            misr      <= MISR_SEED;
            counter   <= '0;
            start_q   <= 1'b0;
            bist_mode <= 1'b0;
            pass_fail <= 1'b0;
            bist_end  <= 1'b0;
        end else begin
            start_q <= bist_start;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_pulse) begin
                        state     <= S_RUN;
                        lfsr      <= SEED_EFF;
                        misr      <= MISR_SEED;
                        counter   <= '0;
                        bist_mode <= 1'b1;
                        pass_fail <= 1'b0;
                        bist_end  <= 1'b0;
                    end
                end
                S_RUN: begin
                    lfsr    <= lfsr_next;
                    counter <= counter + CNT_W'(1);
                    if (capture) begin
                        misr <= misr_next;
                    end
                    if (last_cycle) begin
                        state     <= S_CHECK;
                        bist_mode <= 1'b0;
                    end
                end
                S_CHECK: begin
                    pass_fail <= (misr == GOLDEN_SIG);
                    bist_end  <= 1'b1;
                    state     <= S_DONE;
                end
                default: begin
                    state     <= S_IDLE;
                    bist_mode <= 1'b0;
                    bist_end  <= 1'b0;
                    pass_fail <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl_param.sv
// tb/tb_bist_ctrl_param.sv - directed bench for bist_ctrl_param (default and CUT_LAT=3 instances)
module tb_bist_ctrl_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bist_start;
    logic [7:0] func_in;
    logic [7:0] cut_out0;
    logic [7:0] cut_in0, cut_in1;
    logic       bist_mode0, bist_mode1;
    logic       pass_fail0, pass_fail1;
    logic       bist_end0, bist_end1;
    logic [7:0] d1, d2, d3;
`ifdef BIST_SIG_OUT_EN
    logic [7:0] sig_out0, sig_out1;
    logic       sig_valid0, sig_valid1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    bist_ctrl_param u_dut0 (
        .CLK        (CLK),
        .RST        (RST),
        .bist_start (bist_start),
        .func_in    (func_in),
        .cut_out    (cut_out0),
        .cut_in     (cut_in0),
        .bist_mode  (bist_mode0),
        .pass_fail  (pass_fail0),
`ifdef BIST_SIG_OUT_EN
        .sig_out    (sig_out0),
        .sig_valid  (sig_valid0),
`endif
        .bist_end   (bist_end0)
    );

    bist_ctrl_param #(.CUT_LAT(3)) u_dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .bist_start (bist_start),
        .func_in    (func_in),
        .cut_out    (d3),
        .cut_in     (cut_in1),
        .bist_mode  (bist_mode1),
        .pass_fail  (pass_fail1),
`ifdef BIST_SIG_OUT_EN
        .sig_out    (sig_out1),
        .sig_valid  (sig_valid1),
`endif
        .bist_end   (bist_end1)
    );

    // CUT model for the latency instance: a pure 3-cycle delay of its stimulus.
    always @(posedge CLK) begin
        d1 <= cut_in1;
        d2 <= d1;
        d3 <= d2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], ^(m & 8'hB8)} ^ d;
    endfunction

    // Launch a run and step 260 edges past the start edge, recording when each bist_end rises.
    task automatic run_cycles(input int fault_k, input int hold_cycles, output int e0, output int e1);
        logic [7:0] seq [5];
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h11;
        e0 = -1;
        e1 = -1;
        cut_out0   = 8'h00;
        bist_start = 1'b1;
        tick;
        for (int k = 0; k < 260; k++) begin
            if (k == 0) begin
                check("start_clears_end", {31'd0, bist_end0}, 32'd0);
                check("start_clears_pf", {31'd0, pass_fail0}, 32'd0);
                check("run_mode", {31'd0, bist_mode0}, 32'd1);
            end
            if (k < 5) begin
                check($sformatf("lfsr0_%0d", k), {24'd0, cut_in0}, {24'd0, seq[k]});
                check($sformatf("lfsr1_%0d", k), {24'd0, cut_in1}, {24'd0, seq[k]});
            end
            if (k >= hold_cycles) bist_start = 1'b0;
            cut_out0 = (k == fault_k) ? 8'h01 : 8'h00;
            tick;
            if (bist_end0 && e0 < 0) e0 = k + 1;
            if (bist_end1 && e1 < 0) e1 = k + 1;
        end
        bist_start = 1'b0;
        cut_out0   = 8'h00;
    endtask

    initial begin
        int e0, e1;
        int seen;
        logic [7:0] model1, model_fault, l;

        // Reference signatures.
        model1 = 8'h00;
        l = 8'h01;
        for (int i = 0; i < 200; i++) begin
            model1 = misr_step(model1, l);
            l = lfsr_step(l);
        end
        model_fault = 8'h00;
        for (int k = 0; k < 200; k++) begin
            model_fault = misr_step(model_fault, (k == 57) ? 8'h01 : 8'h00);
        end

        RST = 1'b1;
        bist_start = 1'b0;
        func_in = 8'h5A;
        cut_out0 = 8'h00;

        // Reset hold.
        for (int i = 0; i < 6; i++) begin
            func_in = 8'h30 + 8'(i);
            tick;
            check("rst_outs", {29'd0, bist_end0, pass_fail0, bist_mode0}, 32'd0);
            check("rst_cut_in", {24'd0, cut_in0}, {24'd0, func_in});
        end
        RST = 1'b0;
        tick;
        func_in = 8'hA5;
        #1;
        check("idle_cut_in", {24'd0, cut_in0}, 32'h0000_00A5);

        // Pass case, start held for 10 cycles, plus CUT_LAT=3 instance.
        run_cycles(-1, 10, e0, e1);
        check("pass_end_lat", e0, 201);
        check("lat3_end_lat", e1, 204);
        check("pass_end", {31'd0, bist_end0}, 32'd1);
        check("pass_pf", {31'd0, pass_fail0}, 32'd1);
        check("pass_sig", {24'd0, u_dut0.misr}, 32'd0);
        check("lat3_sig", {24'd0, u_dut1.misr}, {24'd0, model1});
        check("lat3_pf", {31'd0, pass_fail1}, {31'd0, (model1 == 8'h00)});
        check("done_mode", {31'd0, bist_mode0}, 32'd0);
        func_in = 8'hC3;
        #1;
        check("done_cut_in", {24'd0, cut_in0}, 32'h0000_00C3);

        // Fault case from DONE; start held high through DONE must not retrigger.
        run_cycles(57, 240, e0, e1);
        check("fail_end_lat", e0, 201);
        check("fail_end", {31'd0, bist_end0}, 32'd1);
        check("fail_pf", {31'd0, pass_fail0}, 32'd0);
        check("fail_sig", {24'd0, u_dut0.misr}, {24'd0, model_fault});

        // Retrigger: identical result to the pass run.
        run_cycles(-1, 1, e0, e1);
        check("rerun_end_lat", e0, 201);
        check("rerun_pf", {31'd0, pass_fail0}, 32'd1);

        // Mid-run reset at RUN cycle 100.
        bist_start = 1'b1;
        tick;
        bist_start = 1'b0;
        repeat (100) tick;
        check("abort_in_run", {31'd0, bist_mode0}, 32'd1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        check("abort_mode", {31'd0, bist_mode0}, 32'd0);
        check("abort_cut_in", {24'd0, cut_in0}, {24'd0, func_in});
        seen = 0;
        for (int i = 0; i < 260; i++) begin
            tick;
            if (bist_end0 || pass_fail0) seen = 1;
        end
        check("abort_no_end", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
